// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 width/sign codes,
// FSM state encoding, bus width and helpers for op legality and alignment.
package lsu_pkg;

    localparam int ADDR_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_e;

    // Unsigned variants exist only for loads.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Width is carried in funct3[1:0]; only illegal codes reach 2'b11.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lane);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = lane[0];
            2'b10:   mis = (lane != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// lsu_lane_align: purely combinational byte-lane logic.
//   Store side: replicates store_data across lanes and builds byte strobes
//     st_funct3, st_lane, st_is_store, store_data -> wdata, wstrb
//   Load side: shifts the read word down by lane and sign/zero-extends
//     ld_funct3, ld_lane, rdata -> load_ext
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]        st_funct3,
    input  logic [1:0]        st_lane,
    input  logic              st_is_store,
    input  logic [ADDR_W-1:0] store_data,
    output logic [ADDR_W-1:0] wdata,
    output logic [3:0]        wstrb,
    input  logic [2:0]        ld_funct3,
    input  logic [1:0]        ld_lane,
    input  logic [ADDR_W-1:0] rdata,
    output logic [ADDR_W-1:0] load_ext
);

    logic [ADDR_W-1:0] shifted;

    always_comb begin
        wdata = store_data;
        wstrb = 4'hF;
        case (st_funct3)
            F3_B: begin
                wdata = {4{store_data[7:0]}};
                wstrb = 4'b0001 << st_lane;
            end
            F3_H: begin
                wdata = {2{store_data[15:0]}};
                wstrb = 4'b0011 << st_lane;
            end
            default: begin
                wdata = store_data;
                wstrb = 4'hF;
            end
        endcase
        if (!st_is_store) begin
            wstrb = 4'h0;
        end
    end

    always_comb begin
        shifted  = rdata >> {ld_lane, 3'b000};
        load_ext = shifted;
        case (ld_funct3)
            F3_B:    load_ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_ext = {24'h0, shifted[7:0]};
            F3_HU:   load_ext = {16'h0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage. Forms ea = base + imm, runs a single
// load or store over a req/ack data bus and returns extended load data.
//   start/mem_read/mem_write/funct3/base/imm/store_data : request from pipeline
//   busy, done, err, load_data                          : status/result to CPU
//   bus_req/bus_we/bus_addr/bus_wdata/bus_wstrb         : data-memory request
//   bus_rdata/bus_ack                                   : data-memory response
//
// state  | meaning
// IDLE   | waiting for start; requests checked and latched here
// ACCESS | bus_req held, waiting for bus_ack or timeout
// DONE   | done pulse with err valid, back to IDLE next cycle
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = lsu_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] imm,
    input  logic [ADDR_W-1:0] store_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] load_data,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [ADDR_W-1:0] bus_wdata,
    output logic [3:0]        bus_wstrb,
    input  logic [ADDR_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e        state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] load_data_q, load_data_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [ADDR_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_wstrb_q, bus_wstrb_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lane_q, lane_d;
    logic              is_load_q, is_load_d;

    logic [ADDR_W-1:0] ea;
    logic              req_valid;
    logic              req_bad;
    logic [ADDR_W-1:0] al_wdata;
    logic [3:0]        al_wstrb;
    logic [ADDR_W-1:0] al_load;

    assign ea = base + imm;

    lsu_lane_align u_align (
        .st_funct3  (funct3),
        .st_lane    (ea[1:0]),
        .st_is_store(mem_write),
        .store_data (store_data),
        .wdata      (al_wdata),
        .wstrb      (al_wstrb),
        .ld_funct3  (f3_q),
        .ld_lane    (lane_q),
        .rdata      (bus_rdata),
        .load_ext   (al_load)
    );

    // A request with neither direction set is a no-op, not an error.
    assign req_valid = start && (mem_read || mem_write);
    assign req_bad   = (mem_read && mem_write)
                     || !f3_legal(funct3, mem_write)
                     || f3_misaligned(funct3, ea[1:0]);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        load_data_d = load_data_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wstrb_d = bus_wstrb_q;
        f3_d        = f3_q;
        lane_d      = lane_q;
        is_load_d   = is_load_q;

        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (req_valid) begin
                    if (req_bad) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = ACCESS;
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_write;
                        bus_addr_d  = {ea[ADDR_W-1:2], 2'b00};
                        bus_wdata_d = al_wdata;
                        bus_wstrb_d = al_wstrb;
                        f3_d        = funct3;
                        lane_d      = ea[1:0];
                        is_load_d   = mem_read;
                    end
                end
            end
            ACCESS: begin
                // An ack on the last allowed cycle still counts as success.
                if (bus_ack) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    if (is_load_q) begin
                        load_data_d = al_load;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
                bus_we_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            load_data_q <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= 4'h0;
            f3_q        <= 3'b000;
            lane_q      <= 2'b00;
            is_load_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            load_data_q <= load_data_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wstrb_q <= bus_wstrb_d;
            f3_q        <= f3_d;
            lane_q      <= lane_d;
            is_load_q   <= is_load_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign load_data = load_data_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wstrb = bus_wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] base = '0;
    logic [31:0] imm = '0;
    logic [31:0] store_data = '0;
    logic        busy, done, err, bus_req, bus_we;
    logic [31:0] load_data, bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .base(base), .imm(imm),
        .store_data(store_data), .busy(busy), .done(done), .err(err),
        .load_data(load_data), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    int n_vec = 0;
    int n_miss = 0;

    // expected outputs for the current cycle, consumed by the compare process
    bit          exp_valid = 0;
    logic        exp_busy, exp_done, exp_err, exp_req, exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_ld;
    logic [3:0]  exp_wstrb;
    logic [31:0] model_ld = '0;

    // observations of the last transaction, pinned against literals
    int          cyc, obs_lat, req_cycles;
    logic        obs_err, obs_we;
    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_wstrb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_valid) begin
            check("busy", 32'(busy), 32'(exp_busy));
            check("done", 32'(done), 32'(exp_done));
            check("bus_req", 32'(bus_req), 32'(exp_req));
            check("load_data", load_data, exp_ld);
            if (exp_done) check("err", 32'(err), 32'(exp_err));
            if (exp_req) begin
                check("bus_we", 32'(bus_we), 32'(exp_we));
                check("bus_addr", bus_addr, exp_addr);
                check("bus_wstrb", 32'(bus_wstrb), 32'(exp_wstrb));
                if (exp_we) check("bus_wdata", bus_wdata, exp_wdata);
            end
        end
    end

    // ---------------- behavioural model ----------------
    function automatic int m_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit m_legal(input logic [2:0] f3, input bit st);
        if (st) return f3 inside {3'd0, 3'd1, 3'd2};
        return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] rd);
        logic [31:0] sh;
        byte         sb;
        shortint     shw;
        sh  = rd >> (8 * int'(lane));
        sb  = byte'(sh[7:0]);
        shw = shortint'(sh[15:0]);
        case (f3)
            3'd0:    return 32'(int'(sb));
            3'd1:    return 32'(int'(shw));
            3'd4:    return sh & 32'h0000_00FF;
            3'd5:    return sh & 32'h0000_FFFF;
            default: return rd;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (m_size(f3))
            1:       return (sd & 32'hFF) * 32'h0101_0101;
            2:       return (sd & 32'hFFFF) * 32'h0001_0001;
            default: return sd;
        endcase
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [1:0] lane);
        case (m_size(f3))
            1:       return 4'(1 << lane);
            2:       return 4'(3 << lane);
            default: return 4'hF;
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus_req) req_cycles++;
        if (done && obs_lat < 0) begin
            obs_lat = cyc;
            obs_err = err;
        end
    endtask

    task automatic set_idle();
        exp_busy = 0; exp_done = 0; exp_err = 0; exp_req = 0; exp_we = 0;
        exp_ld = model_ld;
    endtask

    // start requests while busy must be ignored
    task automatic junk();
        start      = 1'($urandom_range(0, 1));
        mem_read   = 1'($urandom_range(0, 1));
        mem_write  = 1'($urandom_range(0, 1));
        funct3     = 3'($urandom_range(0, 7));
        base       = $urandom;
        imm        = $urandom;
        store_data = $urandom;
    endtask

    // waits < 0 means memory never acks
    task automatic txn(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] b, input logic [31:0] im, input logic [31:0] sd,
                       input logic [31:0] rdata, input int waits);
        logic [31:0] ea;
        logic [1:0]  lane;
        bit          bad;
        int          n;
        ea   = b + im;
        lane = ea[1:0];
        bad  = (rd && wr) || !m_legal(f3, wr) || ((ea % 32'(m_size(f3))) != 0);
        cyc = 0; obs_lat = -1; req_cycles = 0; obs_err = 1'bx;
        start = 1; mem_read = rd; mem_write = wr; funct3 = f3;
        base = b; imm = im; store_data = sd;
        bus_ack = 1'($urandom_range(0, 1));
        tick();
        if (!rd && !wr) begin
            start = 0; bus_ack = 0;
            return;
        end
        if (bad) begin
            exp_busy = 1; exp_done = 1; exp_err = 1; exp_req = 0;
            junk();
            bus_ack = 1'($urandom_range(0, 1));
            tick();
            set_idle();
            start = 0; bus_ack = 0;
            return;
        end
        n = (waits < 0) ? TO : waits + 1;
        for (int i = 0; i < n; i++) begin
            exp_busy = 1; exp_done = 0; exp_req = 1; exp_we = wr;
            exp_addr  = ea & 32'hFFFF_FFFC;
            exp_wstrb = wr ? m_wstrb(f3, lane) : 4'h0;
            exp_wdata = m_wdata(f3, sd);
            if (i == 0) begin
                obs_we = bus_we; obs_addr = bus_addr; obs_wdata = bus_wdata; obs_wstrb = bus_wstrb;
            end
            junk();
            bus_ack   = (i == waits);
            bus_rdata = (i == waits) ? rdata : $urandom;
            tick();
        end
        exp_busy = 1; exp_done = 1; exp_req = 0; exp_err = (waits < 0);
        if (rd && waits >= 0) model_ld = m_load(f3, lane, rdata);
        exp_ld = model_ld;
        junk();
        bus_ack = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
        tick();
        set_idle();
        start = 0; bus_ack = 0;
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_req", 32'(bus_req), 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        check("rst_wdata", bus_wdata, 32'd0);
        check("rst_wstrb", 32'(bus_wstrb), 32'd0);
        check("rst_load_data", load_data, 32'd0);
        @(negedge clk);
        rst_n = 1;
        tick();
        set_idle();
        exp_valid = 1;
        tick();

        // LW with wrapping address
        txn(1, 0, 3'd2, 32'h1000, 32'hFFFF_FFFC, 0, 32'hDEAD_BEEF, 0);
        check("lw_addr", obs_addr, 32'h0000_0FFC);
        check("lw_latency", 32'(obs_lat), 32'd2);
        check("lw_err", 32'(obs_err), 32'd0);
        check("lw_data", load_data, 32'hDEAD_BEEF);
        // LB / LBU at lane 3
        txn(1, 0, 3'd0, 32'h2000, 32'd3, 0, 32'h8012_3456, 1);
        check("lb_data", load_data, 32'hFFFF_FF80);
        txn(1, 0, 3'd4, 32'h2000, 32'd3, 0, 32'h8012_3456, 2);
        check("lbu_data", load_data, 32'h0000_0080);
        // SH at lane 2
        txn(0, 1, 3'd1, 32'h3000, 32'd2, 32'h0000_ABCD, 0, 1);
        check("sh_we", 32'(obs_we), 32'd1);
        check("sh_wdata", obs_wdata, 32'hABCD_ABCD);
        check("sh_wstrb", 32'(obs_wstrb), 32'b1100);
        check("sh_addr", obs_addr, 32'h0000_3000);
        check("sh_keeps_load_data", load_data, 32'h0000_0080);
        // misaligned LW, then illegal funct3
        txn(1, 0, 3'd2, 32'h4000, 32'd2, 0, 0, 0);
        check("mis_latency", 32'(obs_lat), 32'd1);
        check("mis_err", 32'(obs_err), 32'd1);
        check("mis_no_req", 32'(req_cycles), 32'd0);
        txn(1, 0, 3'd3, 32'h4000, 32'd0, 0, 0, 0);
        check("f3_011_err", 32'(obs_err), 32'd1);
        // timeout, and ack exactly on the final cycle
        txn(1, 0, 3'd2, 32'h5000, 32'd0, 0, 32'h1234_5678, -1);
        check("to_req_cycles", 32'(req_cycles), 32'd16);
        check("to_err", 32'(obs_err), 32'd1);
        check("to_latency", 32'(obs_lat), 32'd17);
        txn(1, 0, 3'd2, 32'h5000, 32'd4, 0, 32'h1234_5678, TO - 1);
        check("late_ack_err", 32'(obs_err), 32'd0);
        check("late_ack_data", load_data, 32'h1234_5678);

        // randomized traffic
        for (int t = 0; t < 300; t++) begin
            int          sel, w;
            bit          rd, wr;
            logic [2:0]  f3;
            logic [31:0] b;
            sel = int'($urandom_range(0, 9));
            rd  = (sel == 1) || (sel >= 2 && sel < 6);
            wr  = (sel == 1) || (sel >= 6);
            if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
            else if (wr)                   f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end
            b = $urandom;
            if ($urandom_range(0, 1) == 1) b = b & 32'hFFFF_FFFC;
            w = ($urandom_range(0, 14) == 0) ? -1 : int'($urandom_range(0, 4));
            txn(rd, wr, f3, b, 32'(int'($urandom_range(0, 4095)) - 2048), $urandom, $urandom, w);
        end

        // async reset in the middle of ACCESS with an ack arriving
        exp_valid = 0;
        start = 1; mem_read = 1; mem_write = 0; funct3 = 3'd2; base = 32'h6000; imm = 0;
        tick();
        start = 0;
        tick();
        tick();
        check("pre_rst_req", 32'(bus_req), 32'd1);
        bus_ack = 1; bus_rdata = 32'hCAFE_F00D;
        rst_n = 0;
        #1;
        check("rst_mid_req", 32'(bus_req), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        tick();
        rst_n = 1;
        model_ld = '0;
        set_idle();
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_ld", load_data, 32'd0);
        bus_ack = 0;
        exp_valid = 1;
        repeat (3) tick();
        txn(1, 0, 3'd5, 32'h7000, 32'd2, 0, 32'h8001_7FFF, 0);
        check("lhu_after_rst", load_data, 32'h0000_8001);

        exp_valid = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of the immediate generator. It consumes the sign-extended I-type/S-type immediate plus the rs1 base value and computes the effective address. It then runs one load or store transaction on the data-memory bus through a req/ack handshake, and returns aligned, sign/zero-extended load data to writeback. The CPU stalls while the unit reports busy.

Parameters:
TIMEOUT_CYCLES, 16, bus-wait cycles in ACCESS before aborting with err (valid range 1..255)
ADDR_W, 32, address/data width (fixed at 32; parameter exists only for package consistency)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request pulse; sampled only in IDLE
mem_read  input  1  load operation
mem_write  input  1  store operation
funct3  input  3  RV32I width/sign code
base  input  32  rs1 value
imm  input  32  sign-extended immediate from ImmGen
store_data  input  32  rs2 value
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle completion pulse
err  output  1  valid with done: misaligned, illegal funct3, read&write both set, or timeout
load_data  output  32  extended load result; held until next done
bus_req  output  1  memory request, held until ack
bus_we  output  1  1 = write
bus_addr  output  32  word-aligned address {ea[31:2],2'b00}
bus_wdata  output  32  lane-replicated store data
bus_wstrb  output  4  byte enables
bus_rdata  input  32  read word, valid with bus_ack
bus_ack  input  1  one-cycle completion from memory

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, err, bus_req, bus_we = 0; bus_addr, bus_wdata, load_data = 0; bus_wstrb = 0; timeout counter = 0. Reset mid-transaction drops bus_req immediately; the stale ack is ignored.
- ea = base + imm, modulo 2^32 (wraps, no fault). lane = ea[1:0].
- funct3 loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW. Any other code is illegal.
- Misaligned: halfword with lane[0]=1; word with lane!=0.
- States IDLE, ACCESS, DONE.
- IDLE: start with neither mem_read nor mem_write -> ignored, stays IDLE. start with (read^write) and a legal, aligned op -> register ea, op, and funct3; drive bus_req=1; go ACCESS next cycle. start with an illegal, misaligned, or read&write op -> DONE with err=1 and no bus activity.
- ACCESS: bus_req, bus_we, bus_addr, bus_wdata, and bus_wstrb are stable every cycle until ack. On bus_ack: drop bus_req the next cycle, capture load_data for loads, go DONE. The counter increments each cycle without ack; counter == TIMEOUT_CYCLES-1 with no ack -> drop bus_req, go DONE with err=1. An ack in the same cycle as the timeout takes priority (success).
- DONE: done=1 for exactly one cycle, err valid, then IDLE. start in DONE or ACCESS is ignored (busy=1).
- Latency: start to done = 2 + wait cycles (ack in the first ACCESS cycle gives done 2 cycles after start). Error without bus activity gives done 1 cycle after start.
- Store lanes: SB wdata={4{b}}, wstrb=4'b0001<<lane. SH wdata={2{h}}, wstrb=4'b0011<<lane. SW wstrb=4'hF. For loads, wstrb=0.
- Load extract: byte = rdata>>(8*lane)[7:0]; half = rdata>>(8*lane)[15:0]; sign- or zero-extend per funct3. On error or store, load_data is unchanged.
- bus_ack outside ACCESS is ignored.

Decomposition:
- Shared package lsu_pkg holds: funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU), state encoding (IDLE, ACCESS, DONE), and the ADDR_W constant.
- One combinational sub-module, lsu_lane_align, performs store replication and strobe generation plus load extraction and extension. The FSM, counter, and registers remain in load_store_unit.

Test Plan:
- LW: base=0x1000, imm=0xFFFFFFFC, ack after 0 waits, rdata=0xDEADBEEF -> bus_addr=0x0FFC, done 2 cycles after start, load_data=0xDEADBEEF, err=0.
- LB then LBU at ea=0x2003, rdata=0x80123456 -> LB gives load_data=0xFFFFFF80; LBU gives 0x00000080.
- SH: base=0x3000, imm=2, store_data=0x0000ABCD -> bus_we=1, bus_wdata=0xABCDABCD, bus_wstrb=4'b1100, bus_addr=0x3000.
- LW with ea=0x4002 -> no bus_req, done next cycle with err=1. Separately, funct3=011 -> err=1.
- No ack with TIMEOUT_CYCLES=16 -> bus_req drops after 16 ACCESS cycles, done with err=1. A second start during busy is ignored.
- rst_n asserted mid-ACCESS while a late ack arrives -> bus_req=0 immediately, busy=0, no done, ack ignored.
